// File: rtl/n_bit_seq_adder_if.sv
// -----------------------------------------------------------------------------
// n_bit_seq_adder_if
//
// Purpose: bundles the operand handshake and the result handshake of the
// sequential adder/subtractor into one interface.
//
// Signals:
//   in_valid   producer -> adder   operands and mode are valid
//   in_ready   adder -> producer   adder can accept operands
//   input1     producer -> adder   operand A (WIDTH bits)
//   input2     producer -> adder   operand B (WIDTH bits)
//   sub        producer -> adder   0: A+B, 1: A-B
//   out_valid  adder -> consumer   result registers hold a completed result
//   out_ready  consumer -> adder   consumer accepts the result
//   answer     adder -> consumer   sum/difference modulo 2^WIDTH
//   carry_out  adder -> consumer   carry out of MSB (NOT-borrow for sub)
//   overflow   adder -> consumer   two's-complement overflow
//
// Modports: master = the side that supplies operands and takes results,
//           slave  = the adder itself.
// -----------------------------------------------------------------------------
interface n_bit_seq_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] answer;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, input1, input2, sub, out_ready,
        input  in_ready, out_valid, answer, carry_out, overflow
    );

    modport slave (
        input  in_valid, input1, input2, sub, out_ready,
        output in_ready, out_valid, answer, carry_out, overflow
    );
endinterface

// File: rtl/n_bit_seq_adder.sv
// -----------------------------------------------------------------------------
// n_bit_seq_adder
//
// Purpose: multi-cycle adder/subtractor. Operands are captured on a
// valid/ready handshake, then summed CHUNK bits per clock with a registered
// ripple carry, so no carry chain longer than CHUNK bits exists between
// registers. The result, carry-out and signed-overflow flag are presented on
// a second valid/ready handshake.
//
// Parameters:
//   WIDTH  operand/result width (default 32)
//   CHUNK  bits added per clock (default 8); WIDTH must be a multiple of
//          CHUNK and 1 <= CHUNK <= WIDTH
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   bus    n_bit_seq_adder_if.slave (both handshakes, operands and results)
//
// Latency: out_valid rises NCHUNK edges after the accepting edge.
// Throughput: one operation every NCHUNK+2 cycles with out_ready held high.
// -----------------------------------------------------------------------------
module n_bit_seq_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic               clk,
    input  logic               rst,
    n_bit_seq_adder_if.slave   bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] ans_q, ans_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    logic             in_ready;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             cnext;
    logic             last_chunk;

    // One CHUNK-bit slice of the ripple: returns {carry, sum}.
    function automatic logic [CHUNK:0] add_chunk(
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b,
        input logic             cin
    );
        return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    endfunction

    assign in_ready = (state_q == IDLE) && !rst;

    // Select the slice addressed by the chunk index.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k_q == KW'(i)) begin
                a_chunk = opa_q[i*CHUNK +: CHUNK];
                b_chunk = opb_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign {cnext, s_chunk} = add_chunk(a_chunk, b_chunk, c_q);
    assign last_chunk       = (k_q == KW'(NCHUNK - 1));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        c_d     = c_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        ans_d   = ans_q;
        co_d    = co_q;
        ov_d    = ov_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    // Subtraction is A + ~B + 1: the +1 enters as the
                    // initial carry.
                    opa_d   = bus.input1;
                    opb_d   = bus.sub ? ~bus.input2 : bus.input2;
                    c_d     = bus.sub;
                    k_d     = '0;
                    ans_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                for (int i = 0; i < NCHUNK; i++) begin
                    if (k_q == KW'(i)) begin
                        ans_d[i*CHUNK +: CHUNK] = s_chunk;
                    end
                end
                c_d = cnext;
                k_d = k_q + 1'b1;
                if (last_chunk) begin
                    co_d    = cnext;
                    // The carry into the MSB equals a^b^sum at that bit, so
                    // no separate tap into the adder is needed.
                    ov_d    = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1]
                            ^ s_chunk[CHUNK-1] ^ cnext;
                    state_d = DONE;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and visible result state: reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            c_q     <= 1'b0;
            ans_q   <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            c_q     <= c_d;
            ans_q   <= ans_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    // Operand registers are only consumed after a fresh capture.
    always_ff @(posedge clk) begin
        opa_q <= opa_d;
        opb_q <= opb_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.answer    = ans_q;
    assign bus.carry_out = co_q;
    assign bus.overflow  = ov_q;

endmodule
